// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM states and engine modes for the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] ALUOP_PD1 = 4'h0;
    localparam logic [3:0] ALUOP_PD2 = 4'h1;
    localparam logic [3:0] ALUOP_ADD = 4'h2;
    localparam logic [3:0] ALUOP_ZER = 4'h3;
    localparam logic [3:0] ALUOP_SUB = 4'h4;
    localparam logic [3:0] ALUOP_AND = 4'h5;
    localparam logic [3:0] ALUOP_OR  = 4'h6;
    localparam logic [3:0] ALUOP_XOR = 4'h7;
    localparam logic [3:0] ALUOP_SHL = 4'h8;
    localparam logic [3:0] ALUOP_SHR = 4'h9;
    localparam logic [3:0] ALUOP_MUL = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] ENG_SHL = 2'd0;
    localparam logic [1:0] ENG_SHR = 2'd1;
    localparam logic [1:0] ENG_MUL = 2'd2;

endpackage

// File: rtl/alu_seq_shift_mul.sv
// Serial shift / shift-add multiply engine: one step per cycle, count-zero marks the last step.
// Next-step values are exposed combinationally so the caller can register the final result on that step.
module alu_seq_shift_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [1:0]       mode_i,
    input  logic [SHW-1:0]   cnt_i,
    input  logic [WIDTH-1:0] acc_i,
`ifdef ALU_SEQ_MUL_EN
    input  logic [WIDTH-1:0] mcand_i,
`endif
    output logic             cnt_zero_o,
    output logic [WIDTH-1:0] res_nxt_o,
    output logic             c_nxt_o,
    output logic             of_nxt_o
);

    logic [1:0]         mode_q;
    logic [SHW-1:0]     cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic               c_d;
    logic               hi_nz;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH:0]     psum;
`endif

    always_comb begin
        acc_d = acc_q;
        c_d   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        psum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
`endif
        case (mode_q)
            ENG_SHL: begin
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
                c_d   = acc_q[WIDTH-1];
            end
            ENG_SHR: begin
                acc_d = {acc_q[2*WIDTH-1:WIDTH], 1'b0, acc_q[WIDTH-1:1]};
                c_d   = acc_q[0];
            end
`ifdef ALU_SEQ_MUL_EN
            // Multiplier sits in the low half and is consumed as the partial product shifts in.
            ENG_MUL: acc_d = {psum, acc_q[WIDTH-1:1]};
`endif
            default: ;
        endcase
    end

    assign hi_nz      = |acc_d[2*WIDTH-1:WIDTH];
    assign cnt_zero_o = (cnt_q == '0);
    assign res_nxt_o  = acc_d[WIDTH-1:0];
    assign c_nxt_o    = (mode_q == ENG_MUL) ? hi_nz : c_d;
    assign of_nxt_o   = (mode_q == ENG_MUL) ? hi_nz : 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= ENG_SHL;
            cnt_q   <= '0;
            acc_q   <= '0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q <= '0;
`endif
        end else if (load_i) begin
            mode_q  <= mode_i;
            cnt_q   <= cnt_i;
            acc_q   <= {{WIDTH{1'b0}}, acc_i};
`ifdef ALU_SEQ_MUL_EN
            mcand_q <= mcand_i;
`endif
        end else if (step_i) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake; single-cycle ops done next cycle, shifts take k cycles, MUL WIDTH.
// Start is ignored while busy (no queueing); define ALU_SEQ_MUL_EN to build the serial multiplier.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Start,
    input  logic [3:0]       i_ALUOp,
    input  logic [WIDTH-1:0] i_Data1,
    input  logic [WIDTH-1:0] i_Data2,
    output logic [WIDTH-1:0] o_Result,
    output logic             o_Z,
    output logic             o_S,
    output logic             o_C,
    output logic             o_OF,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Illegal
);

    state_t           state_q;
    logic [WIDTH-1:0] result_q, res_d;
    logic             z_q, s_q, c_q, of_q;
    logic             z_d, s_d, c_d, of_d;
    logic             busy_q, done_q, illegal_q;
    logic             start_ok, multi, illegal_d, upd_zs;
    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   k;
    logic [1:0]       eng_mode;
    logic [SHW-1:0]   eng_cnt;
    logic [WIDTH-1:0] eng_acc;
    logic             eng_last;
    logic [WIDTH-1:0] eng_res;
    logic             eng_c, eng_of;

    always_comb begin
        start_ok  = i_Start && (state_q != ST_RUN);
        k         = i_Data2[SHW-1:0];
        sum       = {1'b0, i_Data1} + {1'b0, i_Data2};
        diff      = {1'b0, i_Data1} - {1'b0, i_Data2};
        res_d     = result_q;
        z_d       = z_q;
        s_d       = s_q;
        c_d       = c_q;
        of_d      = of_q;
        multi     = 1'b0;
        illegal_d = 1'b0;
        upd_zs    = 1'b0;
        eng_mode  = ENG_SHL;
        eng_cnt   = k - 1'b1;
        eng_acc   = i_Data1;
        case (i_ALUOp)
            ALUOP_PD1: res_d = i_Data1;
            ALUOP_PD2: res_d = i_Data2;
            ALUOP_ADD: begin
                res_d  = sum[WIDTH-1:0];
                c_d    = sum[WIDTH];
                of_d   = (i_Data1[WIDTH-1] == i_Data2[WIDTH-1]) && (sum[WIDTH-1] != i_Data1[WIDTH-1]);
                upd_zs = 1'b1;
            end
            ALUOP_ZER: begin
                res_d = '0;
                z_d   = 1'b1;
            end
            ALUOP_SUB: begin
                res_d  = diff[WIDTH-1:0];
                c_d    = diff[WIDTH];
                of_d   = (i_Data1[WIDTH-1] != i_Data2[WIDTH-1]) && (diff[WIDTH-1] != i_Data1[WIDTH-1]);
                upd_zs = 1'b1;
            end
            ALUOP_AND, ALUOP_OR, ALUOP_XOR: begin
                res_d  = (i_ALUOp == ALUOP_AND) ? (i_Data1 & i_Data2) :
                         (i_ALUOp == ALUOP_OR)  ? (i_Data1 | i_Data2) : (i_Data1 ^ i_Data2);
                c_d    = 1'b0;
                of_d   = 1'b0;
                upd_zs = 1'b1;
            end
            ALUOP_SHL, ALUOP_SHR: begin
                eng_mode = (i_ALUOp == ALUOP_SHL) ? ENG_SHL : ENG_SHR;
                // A zero count never enters RUN: it completes like a pass-through.
                if (k == '0) begin
                    res_d  = i_Data1;
                    c_d    = 1'b0;
                    of_d   = 1'b0;
                    upd_zs = 1'b1;
                end else begin
                    multi = 1'b1;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ALUOP_MUL: begin
                eng_mode = ENG_MUL;
                eng_cnt  = SHW'(WIDTH - 1);
                eng_acc  = i_Data2;
                multi    = 1'b1;
            end
`endif
            default: illegal_d = 1'b1;
        endcase
        if (upd_zs) begin
            z_d = (res_d == '0);
            s_d = res_d[WIDTH-1];
        end
    end

    alu_seq_shift_mul #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_engine (
        .clk_i      (i_Clk),
        .rst_i      (i_Reset),
        .load_i     (start_ok && multi),
        .step_i     (state_q == ST_RUN),
        .mode_i     (eng_mode),
        .cnt_i      (eng_cnt),
        .acc_i      (eng_acc),
`ifdef ALU_SEQ_MUL_EN
        .mcand_i    (i_Data1),
`endif
        .cnt_zero_o (eng_last),
        .res_nxt_o  (eng_res),
        .c_nxt_o    (eng_c),
        .of_nxt_o   (eng_of)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            z_q       <= 1'b0;
            s_q       <= 1'b0;
            c_q       <= 1'b0;
            of_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok && multi) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else if (start_ok) begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        illegal_q <= illegal_d;
                        result_q  <= res_d;
                        z_q       <= z_d;
                        s_q       <= s_d;
                        c_q       <= c_d;
                        of_q      <= of_d;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (eng_last) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= eng_res;
                        z_q      <= (eng_res == '0);
                        s_q      <= eng_res[WIDTH-1];
                        c_q      <= eng_c;
                        of_q     <= eng_of;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_Result  = result_q;
    assign o_Z       = z_q;
    assign o_S       = s_q;
    assign o_C       = c_q;
    assign o_OF      = of_q;
    assign o_Busy    = busy_q;
    assign o_Done    = done_q;
    assign o_Illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8): directed vectors plus randomized ops against an arithmetic reference model.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       i_Reset, i_Start;
    logic [3:0] i_ALUOp;
    logic [7:0] i_Data1, i_Data2;
    logic [7:0] o_Result;
    logic       o_Z, o_S, o_C, o_OF, o_Busy, o_Done, o_Illegal;

    int total = 0;
    int bad   = 0;

    // Reference state: architectural result/flags as they should read after the latest completion.
    logic [7:0] m_res;
    logic       m_z, m_s, m_c, m_of, m_ill;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .i_Clk     (clk),
        .i_Reset   (i_Reset),
        .i_Start   (i_Start),
        .i_ALUOp   (i_ALUOp),
        .i_Data1   (i_Data1),
        .i_Data2   (i_Data2),
        .o_Result  (o_Result),
        .o_Z       (o_Z),
        .o_S       (o_S),
        .o_C       (o_C),
        .o_OF      (o_OF),
        .o_Busy    (o_Busy),
        .o_Done    (o_Done),
        .o_Illegal (o_Illegal)
    );

    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
        int          k, s, ss;
        logic [15:0] w;
        k     = int'(b[2:0]);
        lat   = 0;
        m_ill = 1'b0;
        case (op)
            4'h0: m_res = a;
            4'h1: m_res = b;
            4'h2: begin
                s     = int'(a) + int'(b);
                ss    = int'($signed(a)) + int'($signed(b));
                m_res = 8'(s);
                m_c   = (s > 255);
                m_of  = (ss > 127) || (ss < -128);
                m_z   = (m_res == 8'h00);
                m_s   = m_res[7];
            end
            4'h3: begin
                m_res = 8'h00;
                m_z   = 1'b1;
            end
            4'h4: begin
                s     = int'(a) - int'(b);
                ss    = int'($signed(a)) - int'($signed(b));
                m_res = 8'(s);
                m_c   = (a < b);
                m_of  = (ss > 127) || (ss < -128);
                m_z   = (m_res == 8'h00);
                m_s   = m_res[7];
            end
            4'h5, 4'h6, 4'h7: begin
                m_res = (op == 4'h5) ? (a & b) : (op == 4'h6) ? (a | b) : (a ^ b);
                m_c   = 1'b0;
                m_of  = 1'b0;
                m_z   = (m_res == 8'h00);
                m_s   = m_res[7];
            end
            4'h8: begin
                w     = {8'h00, a} << k;
                m_res = w[7:0];
                m_c   = (k == 0) ? 1'b0 : w[8];
                m_of  = 1'b0;
                m_z   = (m_res == 8'h00);
                m_s   = m_res[7];
                lat   = k;
            end
            4'h9: begin
                w     = {a, 8'h00} >> k;
                m_res = w[15:8];
                m_c   = (k == 0) ? 1'b0 : w[7];
                m_of  = 1'b0;
                m_z   = (m_res == 8'h00);
                m_s   = m_res[7];
                lat   = k;
            end
`ifdef ALU_SEQ_MUL_EN
            4'hA: begin
                w     = 16'(int'(a) * int'(b));
                m_res = w[7:0];
                m_c   = (w[15:8] != 8'h00);
                m_of  = m_c;
                m_z   = (m_res == 8'h00);
                m_s   = m_res[7];
                lat   = 8;
            end
`endif
            default: m_ill = 1'b1;
        endcase
    endtask

    // Issues one op, scrambles inputs after accept, waits (bounded) for o_Done and checks it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int   lat, n;
        logic busy_ok;
        model(op, a, b, lat);
        @(negedge clk);
        i_Start = 1'b1; i_ALUOp = op; i_Data1 = a; i_Data2 = b;
        @(posedge clk); #1;
        i_Start = 1'b0; i_ALUOp = 4'($urandom); i_Data1 = 8'($urandom); i_Data2 = 8'($urandom);
        n = 0; busy_ok = 1'b1;
        while (o_Done !== 1'b1 && n < 20) begin
            if (o_Busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", tag, n, lat); end
        total++;
        if (!busy_ok || o_Busy !== 1'b0) begin bad++; $display("FAIL %s busy: busy_during_run=%0b busy_at_done=%b want 1/0", tag, busy_ok, o_Busy); end
        total++;
        if (o_Result !== m_res) begin bad++; $display("FAIL %s result: got %h want %h", tag, o_Result, m_res); end
        total++;
        if ({o_Z, o_S, o_C, o_OF} !== {m_z, m_s, m_c, m_of})
            begin bad++; $display("FAIL %s flags ZSCO: got %b want %b", tag, {o_Z, o_S, o_C, o_OF}, {m_z, m_s, m_c, m_of}); end
        total++;
        if (o_Illegal !== m_ill) begin bad++; $display("FAIL %s illegal: got %b want %b", tag, o_Illegal, m_ill); end
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        total++;
        if (o_Done !== 1'b0 || o_Busy !== 1'b0) begin bad++; $display("FAIL %s idle done/busy: got %b%b want 00", tag, o_Done, o_Busy); end
    endtask

    task automatic test_reset();
        i_Reset = 1'b1; i_Start = 1'b1; i_ALUOp = 4'h2; i_Data1 = 8'hFF; i_Data2 = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({o_Result, o_Z, o_S, o_C, o_OF, o_Busy, o_Done, o_Illegal} !== 15'h0)
            begin bad++; $display("FAIL reset outputs: got %h/%b%b%b%b%b%b%b want all zero", o_Result, o_Z, o_S, o_C, o_OF, o_Busy, o_Done, o_Illegal); end
        @(negedge clk);
        i_Reset = 1'b0; i_Start = 1'b0;
        m_res = 8'h00; m_z = 1'b0; m_s = 1'b0; m_c = 1'b0; m_of = 1'b0;
        idle_check("after_reset");
    endtask

    task automatic test_directed();
        run_op("add_7f_01", 4'h2, 8'h7F, 8'h01);
        total++;
        if ({o_Result, o_Z, o_S, o_C, o_OF} !== {8'h80, 4'b0101}) begin bad++; $display("FAIL add_const: got %h %b want 80 0101", o_Result, {o_Z, o_S, o_C, o_OF}); end
        run_op("sub_00_01", 4'h4, 8'h00, 8'h01);
        total++;
        if ({o_Result, o_S, o_C, o_OF} !== {8'hFF, 3'b110}) begin bad++; $display("FAIL sub_const: got %h SCO=%b want FF 110", o_Result, {o_S, o_C, o_OF}); end
        run_op("pd1_55", 4'h0, 8'h55, 8'h00);
        total++;
        if ({o_Result, o_S, o_C, o_OF} !== {8'h55, 3'b110}) begin bad++; $display("FAIL pd1_const: got %h SCO=%b want 55 110", o_Result, {o_S, o_C, o_OF}); end
        idle_check("pd1_pulse");
        run_op("shl_81_3", 4'h8, 8'h81, 8'h03);
        total++;
        if ({o_Result, o_C} !== {8'h08, 1'b0}) begin bad++; $display("FAIL shl_const: got %h C=%b want 08 0", o_Result, o_C); end
        run_op("shr_81_1", 4'h9, 8'h81, 8'h01);
        total++;
        if ({o_Result, o_C} !== {8'h40, 1'b1}) begin bad++; $display("FAIL shr_const: got %h C=%b want 40 1", o_Result, o_C); end
        run_op("shl_k0", 4'h8, 8'hA5, 8'hF8);
        run_op("mul_10_10", 4'hA, 8'h10, 8'h10);
`ifdef ALU_SEQ_MUL_EN
        total++;
        if ({o_Result, o_Z, o_C, o_OF} !== {8'h00, 3'b111}) begin bad++; $display("FAIL mul_const: got %h ZCO=%b want 00 111", o_Result, {o_Z, o_C, o_OF}); end
`else
        total++;
        if (o_Illegal !== 1'b1) begin bad++; $display("FAIL mul_illegal: got %b want 1", o_Illegal); end
`endif
        run_op("illegal_f", 4'hF, 8'h12, 8'h34);
        idle_check("illegal_pulse");
    endtask

    task automatic test_ignore_and_reset();
        int   lat, n;
        logic [7:0] a;
        a = 8'($urandom);
        model(4'h8, a, 8'h05, lat);
        @(negedge clk);
        i_Start = 1'b1; i_ALUOp = 4'h8; i_Data1 = a; i_Data2 = 8'h05;
        @(posedge clk); #1;
        i_Start = 1'b0;
        @(posedge clk); #1;
        i_Start = 1'b1; i_ALUOp = 4'h2; i_Data1 = 8'h01; i_Data2 = 8'h01;
        @(posedge clk); #1;
        i_Start = 1'b0;
        n = 2;
        while (o_Done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n !== lat) begin bad++; $display("FAIL ignore_start latency: got %0d want %0d", n, lat); end
        total++;
        if (o_Result !== m_res || o_C !== m_c) begin bad++; $display("FAIL ignore_start result: got %h C=%b want %h C=%b", o_Result, o_C, m_res, m_c); end
        idle_check("ignored_add_not_run");

        @(negedge clk);
        i_Start = 1'b1; i_ALUOp = 4'h8; i_Data1 = 8'hFF; i_Data2 = 8'h05;
        @(posedge clk); #1;
        i_Start = 1'b0;
        @(negedge clk);
        i_Reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({o_Result, o_Z, o_S, o_C, o_OF, o_Busy, o_Done, o_Illegal} !== 15'h0)
            begin bad++; $display("FAIL midrun_reset outputs: got %h/%b%b%b%b%b%b%b want all zero", o_Result, o_Z, o_S, o_C, o_OF, o_Busy, o_Done, o_Illegal); end
        @(negedge clk);
        i_Reset = 1'b0;
        m_res = 8'h00; m_z = 1'b0; m_s = 1'b0; m_c = 1'b0; m_of = 1'b0;
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (o_Done === 1'b1) n++;
        end
        total++;
        if (n !== 0) begin bad++; $display("FAIL midrun_reset done_pulses: got %0d want 0", n); end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic [7:0] a, b;
        a = 8'($urandom); b = 8'($urandom);
        model(4'h2, a, b, lat);
        @(negedge clk);
        i_Start = 1'b1; i_ALUOp = 4'h2; i_Data1 = a; i_Data2 = b;
        @(posedge clk); #1;
        total++;
        if ({o_Done, o_Busy} !== 2'b10 || o_Result !== m_res) begin bad++; $display("FAIL b2b add: done/busy=%b%b res=%h want 10 %h", o_Done, o_Busy, o_Result, m_res); end
        i_ALUOp = 4'h3;
        model(4'h3, a, b, lat);
        @(posedge clk); #1;
        i_Start = 1'b0;
        total++;
        if ({o_Done, o_Busy, o_Z} !== 3'b101 || o_Result !== 8'h00) begin bad++; $display("FAIL b2b zer: done/busy/z=%b%b%b res=%h want 101 00", o_Done, o_Busy, o_Z, o_Result); end
        total++;
        if ({o_S, o_C, o_OF} !== {m_s, m_c, m_of}) begin bad++; $display("FAIL b2b zer_held: got %b want %b", {o_S, o_C, o_OF}, {m_s, m_c, m_of}); end
        idle_check("b2b_end");
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 10)) : 4'($urandom_range(0, 15));
            run_op($sformatf("rnd%0d_op%h", i, op), op, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0) idle_check($sformatf("rnd%0d_gap", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_and_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor of the 8-bit datapath ALU.
- Adds start/done handshake, registered result and flags, SUB/logic ops, and multi-cycle serial shifts and an iterative multiply.
- Sits between register-file read and writeback in the CPU datapath.
- The control FSM stalls on o_Busy.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from i_Data2[SHW-1:0].

Ports:
- i_Clk  in  1  clock; all state updates on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Start  in  1  request; accepted only in IDLE or DONE.
- i_ALUOp  in  4  opcode; sampled at accept.
- i_Data1  in  WIDTH  operand A; sampled at accept.
- i_Data2  in  WIDTH  operand B / shift amount; sampled at accept.
- o_Result  out  WIDTH  registered result; holds until next completion.
- o_Z  out  1  zero flag.
- o_S  out  1  sign flag (result MSB).
- o_C  out  1  carry/borrow/shift-out flag.
- o_OF  out  1  signed-overflow flag.
- o_Busy  out  1  high while an accepted op is in RUN.
- o_Done  out  1  one-cycle pulse; result and flags valid from this cycle on.
- o_Illegal  out  1  registered with o_Done; high if the opcode was illegal.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; o_Result=0; Z,S,C,OF=0; o_Busy=0; o_Done=0; o_Illegal=0.
  - Reset mid-RUN aborts the op with no o_Done pulse.
- FSM states: IDLE, RUN, DONE.
  - Accept occurs when i_Start=1 and state is IDLE or DONE; operands and opcode are latched.
  - An accept in the DONE cycle gives back-to-back issue.
  - i_Start in RUN is ignored; it is not queued.
  - DONE with no start returns to IDLE next cycle.
- Latency, counted from accept edge N:
  - Single-cycle ops: o_Done at N+1.
  - SHL/SHR by k: o_Done at N+1+k; k=0 behaves as single-cycle.
  - MUL: o_Done at N+1+WIDTH.
  - o_Busy is high from N+1 until the cycle before o_Done.
- Opcodes (4-bit):
  - 0 PD1: result = A; flags held.
  - 1 PD2: result = B; flags held.
  - 2 ADD: A+B; C = carry out; OF = (A[msb]==B[msb]) && (R[msb]!=A[msb]); Z, S updated.
  - 3 ZER: result 0; Z=1; S, C, OF held.
  - 4 SUB: A-B; C = borrow (A<B unsigned); OF = (A[msb]!=B[msb]) && (R[msb]!=A[msb]); Z, S updated.
  - 5 AND, 6 OR, 7 XOR: Z, S updated; C=0, OF=0.
  - 8 SHL, 9 SHR (logical): one bit per RUN cycle, k = B[SHW-1:0].
    - C = last bit shifted out; C=0 if k=0.
    - OF=0; Z, S from the final result.
  - A MUL (see Optional Feature).
  - B-F illegal: result and flags held; o_Illegal=1 with o_Done at N+1.
- Arithmetic:
  - All results are truncated to WIDTH.
  - Carry is computed internally at WIDTH+1 bits.
  - Shift count never exceeds 2^SHW-1. A count >=WIDTH runs that many cycles and yields 0.
- Input changes after accept have no effect on the op in flight.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- With it defined, MUL is a WIDTH-cycle unsigned shift-add.
  - o_Result = low WIDTH bits of the 2*WIDTH-bit product.
  - C = OF = (high half != 0); Z, S from the low half.
- Without it, opcode A is treated as illegal: o_Done and o_Illegal at N+1, result and flags held, and no multiplier logic is synthesised.

Decomposition:
- Opcode constants ALUOP_PD1..ALUOP_MUL and state encodings go in the shared Constants.v include.
- One natural sub-module, alu_seq_shift_mul: the serial shift/multiply engine, with load/step/count-zero interface and accumulator and cycle counter.
- The top level holds the FSM, the single-cycle combinational ops and the flag registers.

Test Plan:
- WIDTH=8, ADD A=8'h7F B=8'h01 -> Done at N+1, Result=8'h80, S=1, OF=1, C=0, Z=0.
- SUB A=8'h00 B=8'h01 -> Result=8'hFF, C=1, OF=0, S=1; then PD1 A=8'h55 -> Result=8'h55 with flags unchanged.
- SHL A=8'h81 B=3 -> Busy for 3 cycles, Done at N+4, Result=8'h08, C=0; SHR A=8'h81 B=1 -> Result=8'h40, C=1, Done at N+2.
- With ALU_SEQ_MUL_EN: MUL 8'h10 x 8'h10 -> Done at N+9, Result=8'h00, Z=1, C=OF=1. Without the macro -> o_Illegal=1 at N+1.
- Issue SHL by 5, assert i_Start with an ADD during RUN -> ADD ignored. Assert i_Reset at N+2 -> no Done pulse, all outputs 0 next cycle.
- Back-to-back: ADD accepted at N, ZER accepted in the DONE cycle N+1 -> Done at N+1 and N+2, Busy never high, final Z=1.
